// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Forward-select encodings match the execute-stage operand mux select inputs.
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } haz_state_t;

   localparam logic [3:0] PC_REG = 4'd15;

   // The memory stage holds the younger result, so it wins over writeback.
   function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
      fwd_sel_t sel;
      if (hit_m) begin
         sel = FWD_M;
      end else if (hit_w) begin
         sel = FWD_W;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones; a clear takes priority over an increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // NOTE: state is updated with non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use and PC-write stalls,
// branch flushes, data-memory wait freeze with timeout, and performance counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W  = 4,
   parameter int NUM_SRC     = 3,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ra_d,
   input  logic [NUM_SRC-1:0]            src_valid_d,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ra_e,
   input  logic [NUM_SRC-1:0]            src_valid_e,
   input  logic [REG_ADDR_W-1:0]         wa_e,
   input  logic [REG_ADDR_W-1:0]         wa_m,
   input  logic [REG_ADDR_W-1:0]         wa_w,
   input  logic                          regwrite_e,
   input  logic                          regwrite_m,
   input  logic                          regwrite_w,
   input  logic                          memtoreg_e,
   input  logic                          pcsrc_d,
   input  logic                          pcsrc_e,
   input  logic                          pcsrc_m,
   input  logic                          pcsrc_w,
   input  logic                          branch_taken_e,
   input  logic                          mem_req_m,
   input  logic                          mem_ready,
   output logic [NUM_SRC*2-1:0]          forward_e,
   output logic                          stall_f,
   output logic                          stall_d,
   output logic                          stall_e,
   output logic                          stall_m,
   output logic                          stall_w,
   output logic                          flush_d,
   output logic                          flush_e,
   output logic                          mem_err,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [REG_ADDR_W-1:0] PC_ADDR  = REG_ADDR_W'(PC_REG);
   localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   logic [NUM_SRC*2-1:0] fwd_raw;
   logic [NUM_SRC-1:0]   ldr_hit;
   logic                 ldr_stall;
   logic                 pc_pend;
   logic                 mem_busy;
   logic                 freeze;

   haz_state_t           state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 err_q, err_d;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      logic [REG_ADDR_W-1:0] ra_ex;
      logic [REG_ADDR_W-1:0] ra_dc;
      logic                  use_e;
      logic                  hit_m;
      logic                  hit_w;
      fwd_sel_t              sel;

      assign ra_ex = ra_e[g*REG_ADDR_W +: REG_ADDR_W];
      assign ra_dc = ra_d[g*REG_ADDR_W +: REG_ADDR_W];

      // R15 reads the architectural PC+8, never a forwarded result.
      assign use_e = src_valid_e[g] && (ra_ex != PC_ADDR);
      assign hit_m = use_e && regwrite_m && (ra_ex == wa_m);
      assign hit_w = use_e && regwrite_w && (ra_ex == wa_w);
      assign sel   = fwd_pick(hit_m, hit_w);

      assign fwd_raw[2*g +: 2] = sel;
      assign ldr_hit[g] = src_valid_d[g] && (ra_dc == wa_e) && (ra_dc != PC_ADDR);
   end

   assign forward_e = reset ? fwd_raw : '0;
   assign ldr_stall = memtoreg_e & regwrite_e & (|ldr_hit);
   assign pc_pend   = pcsrc_d | pcsrc_e | pcsrc_m;
   assign mem_busy  = mem_req_m & ~mem_ready;
   assign freeze    = mem_busy | (state_q == ERROR);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_MAX) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else if (mem_busy) begin
               wait_d = wait_q + WAIT_W'(1);
            end else begin
               state_d = RUN;
               wait_d  = '0;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign mem_err = err_q;

   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (!reset) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (freeze) begin
         // Branch flush is deferred: the frozen E register keeps branch_taken_e alive.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         stall_w = 1'b1;
      end else begin
         stall_f = ldr_stall | pc_pend;
         stall_d = ldr_stall & ~branch_taken_e;
         flush_d = pc_pend | pcsrc_w | branch_taken_e;
         flush_e = ldr_stall | branch_taken_e;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (stall_f),
      .clear_i (1'b0),
      .count_o (stall_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (flush_d & reset),
      .clear_i (1'b0),
      .count_o (flush_cnt)
   );

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage ARM core. It replaces the hardwired ForwardAE/ForwardBE=0 and pipeEnable=1 ties in the top level.
- Generates per-source forwarding selects, load-use stalls, PC-write and branch flushes, and multi-cycle data-memory wait freezes.
- Has a timeout watchdog and saturating performance counters. Sits beside the datapath and is driven by stage register addresses and control bits.

Parameters:
- REG_ADDR_W, 4, register address width.
- NUM_SRC, 3, execute-stage source operands tracked (Rn, Rm, Rs).
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before error.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- ra_d  in  NUM_SRC*REG_ADDR_W  decode-stage source register addresses.
- src_valid_d  in  NUM_SRC  decode source actually read.
- ra_e  in  NUM_SRC*REG_ADDR_W  execute-stage source register addresses.
- src_valid_e  in  NUM_SRC  execute source actually read.
- wa_e, wa_m, wa_w  in  REG_ADDR_W each  destination register in E, M and W.
- regwrite_e, regwrite_m, regwrite_w  in  1 each  register write pending in that stage.
- memtoreg_e  in  1  E-stage instruction is a load.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1 each  instruction writes R15.
- branch_taken_e  in  1  branch resolved taken in E.
- mem_req_m  in  1  M stage issuing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- forward_e  out  NUM_SRC*2  per source: 00 register file, 01 ResultW, 10 ALUOutM.
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the pipeline register.
- flush_d, flush_e  out  1 each  clear the pipeline register (bubble).
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (reset=0, async):
  - State goes to RUN; wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - All stall_* outputs are 0; flush_d=flush_e=1 while reset is low; forward_e=0.
- Forwarding (combinational), per source i:
  - If src_valid_e[i], ra_e[i]!=15, regwrite_m and ra_e[i]==wa_m -> 10.
  - Else if the same conditions hold with regwrite_w and wa_w -> 01.
  - Else -> 00.
  - M has priority over W. R15 is never forwarded.
- ldr_stall = memtoreg_e & regwrite_e & OR_i(src_valid_d[i] & ra_d[i]==wa_e & ra_d[i]!=15).
- pc_pend = pcsrc_d | pcsrc_e | pcsrc_m.
- In RUN with mem_busy=0:
  - stall_f = ldr_stall | pc_pend.
  - stall_d = ldr_stall.
  - flush_d = pc_pend | pcsrc_w | branch_taken_e.
  - flush_e = ldr_stall | branch_taken_e.
  - stall_e = stall_m = stall_w = 0.
- mem_busy = mem_req_m & ~mem_ready.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN -> MEM_WAIT when mem_busy; wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready; wait_cnt<=0.
  - MEM_WAIT stays when mem_busy & wait_cnt<MEM_TIMEOUT; wait_cnt increments.
  - MEM_WAIT -> ERROR when wait_cnt==MEM_TIMEOUT & ~mem_ready; mem_err<=1.
  - ERROR is left only by reset.
- Freeze:
  - Whenever mem_busy (in RUN or MEM_WAIT), and always in ERROR, all five stall_* are 1 and flush_d=flush_e=0.
  - Freeze overrides load-use, PC and branch rules. The branch flush is applied on the first non-frozen cycle, because branch_taken_e is held by the frozen E register.
  - mem_ready in the same cycle as mem_req_m means no stall: zero-wait access.
- Counters, registered and saturating at all-ones:
  - stall_cnt +1 every cycle stall_f=1.
  - flush_cnt +1 every cycle flush_d=1 outside reset.
- Simultaneous ldr_stall and branch_taken_e: branch wins for D (flush_d=1, stall_d=0). flush_e=1 either way.

Decomposition:
- Shared package: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), haz_state_t enum (RUN, MEM_WAIT, ERROR), constant PC_REG=4'd15.
- Sub-module: sat_counter, parametrised by width with inc and clear inputs, instantiated twice.

Test Plan:
- Forwarding: ADD r1 in M, SUB reading r1 in E with r1 also in W -> forward_e[0]=10. M regwrite=0 -> 01. ra_e=15 -> 00.
- Load-use: memtoreg_e=1, wa_e=3, ra_d[1]=3 valid -> one cycle of stall_f=stall_d=flush_e=1. stall_cnt 0 -> 1.
- PC write: pcsrc_d pulsed then propagated D->E->M->W -> stall_f high 3 cycles, flush_d high 4 cycles, flush_cnt=4.
- Memory wait: mem_req_m=1, mem_ready low 5 cycles -> all stalls high exactly 5 cycles, flushes 0, return to RUN, mem_err=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held low -> ERROR after 4 wait cycles, mem_err=1, stalls stay high. reset low mid-ERROR -> RUN, counters and mem_err return to 0 immediately (async).
- Branch during freeze: branch_taken_e=1 with mem_busy=1 for 2 cycles -> flush_d=flush_e=0 during the freeze, then 1 in the cycle mem_ready completes.
